// File: rtl/npu_layer_dispatcher.sv
// npu_layer_dispatcher: shortest-remaining-first task scheduler
// feeding the NPU one layer at a time from a small task table.
module npu_layer_dispatcher #(
  parameter int REQST_DEPTH    = 9,
  parameter int NUM_SLOTS      = 8,
  parameter int LAYER_BITWIDTH = 8,
  localparam int IW = $clog2(NUM_SLOTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic [REQST_DEPTH-1:0]    req_task_id,
  input  logic [LAYER_BITWIDTH-1:0] req_num_layers,
  output logic [REQST_DEPTH-1:0]    sel_task,
  output logic                      start_comp_npu,
  input  logic                      compute_done_npu,
  output logic                      retire_vld,
  output logic [REQST_DEPTH-1:0]    retire_task_id,
  output logic                      err_zero_layer,
  output logic [IW:0]               occupancy,
  output logic                      busy
);

  typedef enum logic [2:0] {
    IDLE, SELECT, ISSUE, WAIT, UPDATE
  } state_t;

  state_t state, state_n;

  logic [NUM_SLOTS-1:0]      vld;
  logic [REQST_DEPTH-1:0]    tid [NUM_SLOTS];
  logic [LAYER_BITWIDTH-1:0] rem [NUM_SLOTS];

  logic [IW-1:0]             win_idx;
  logic [IW-1:0]             best_idx;
  logic [LAYER_BITWIDTH-1:0] best_rem;
  logic                      best_ok;
  logic [IW-1:0]             free_idx;
  logic                      accept;
  logic                      acc_write;
  logic                      upd_last;
  logic [NUM_SLOTS-1:0]      clr_mask;
  logic [NUM_SLOTS-1:0]      set_mask;
  logic [NUM_SLOTS-1:0]      vld_after;

  assign req_rdy        = ~&vld;
  assign accept         = req_vld && req_rdy;
  assign acc_write      = accept && (req_num_layers != '0);
  assign upd_last       = (state == UPDATE) &&
                          (rem[win_idx] == LAYER_BITWIDTH'(1));
  assign clr_mask       = upd_last ?
                          (NUM_SLOTS'(1) << win_idx) : '0;
  assign set_mask       = acc_write ?
                          (NUM_SLOTS'(1) << free_idx) : '0;
  assign vld_after      = (vld & ~clr_mask) | set_mask;
  assign start_comp_npu = (state == ISSUE);
  assign busy           = (state != IDLE);

  // Lowest-index free slot for the next accepted request.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!vld[i]) free_idx = IW'(i);
    end
  end

  // Valid slot with fewest remaining layers; ties keep the lower index.
  always_comb begin
    best_idx = '0;
    best_rem = '0;
    best_ok  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (vld[i] && (!best_ok || rem[i] < best_rem)) begin
        best_idx = IW'(i);
        best_rem = rem[i];
        best_ok  = 1'b1;
      end
    end
  end

  // Number of occupied slots.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      occupancy = occupancy + (IW+1)'(vld[i]);
    end
  end

  // Task table: fill on accept, count down and free on layer completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        tid[i] <= '0;
        rem[i] <= '0;
      end
    end else begin
      if (acc_write) begin
        vld[free_idx] <= 1'b1;
        tid[free_idx] <= req_task_id;
        rem[free_idx] <= req_num_layers;
      end
      if (state == UPDATE) begin
        rem[win_idx] <= rem[win_idx] - LAYER_BITWIDTH'(1);
        if (upd_last) vld[win_idx] <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; UPDATE also sees requests landing this cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (|vld) state_n = SELECT;
      SELECT:  state_n = ISSUE;
      ISSUE:   state_n = WAIT;
      WAIT:    if (compute_done_npu) state_n = UPDATE;
      UPDATE:  state_n = (|vld_after) ? SELECT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Latch the winner at each layer boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_idx  <= '0;
      sel_task <= '0;
    end else if (state == SELECT) begin
      win_idx  <= best_idx;
      sel_task <= tid[best_idx];
    end
  end

  // Retire and zero-layer error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_vld     <= 1'b0;
      retire_task_id <= '0;
      err_zero_layer <= 1'b0;
    end else begin
      retire_vld     <= upd_last;
      err_zero_layer <= accept && (req_num_layers == '0);
      if (upd_last) retire_task_id <= tid[win_idx];
    end
  end

endmodule

// File: tb/tb_npu_layer_dispatcher.sv
// Bench for npu_layer_dispatcher: directed scenarios checked every
// cycle against a timeline model, plus literal sequence checks.
module tb_npu_layer_dispatcher;

  localparam int RD = 9;
  localparam int NS = 8;
  localparam int LB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic [RD-1:0] req_task_id = '0;
  logic [LB-1:0] req_num_layers = '0;
  logic [RD-1:0] sel_task;
  logic          start_comp_npu;
  logic          compute_done_npu;
  logic          retire_vld;
  logic [RD-1:0] retire_task_id;
  logic          err_zero_layer;
  logic [3:0]    occupancy;
  logic          busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  npu_layer_dispatcher #(
    .REQST_DEPTH(RD), .NUM_SLOTS(NS), .LAYER_BITWIDTH(LB)
  ) dut (
    .clk(clk), .reset(reset),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_task_id(req_task_id), .req_num_layers(req_num_layers),
    .sel_task(sel_task), .start_comp_npu(start_comp_npu),
    .compute_done_npu(compute_done_npu),
    .retire_vld(retire_vld), .retire_task_id(retire_task_id),
    .err_zero_layer(err_zero_layer),
    .occupancy(occupancy), .busy(busy)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm, input int got[$],
                         input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) chk(nm, got[i], exp[i]);
    end
  endtask

  // NPU stand-in: done pulse npu_lat cycles after each start.
  int   npu_lat = 3;
  int   npu_cnt = -1;
  logic npu_done = 1'b0;
  logic spur = 1'b0;
  assign compute_done_npu = npu_done | spur;

  always @(negedge clk) begin
    #1;
    npu_done = 1'b0;
    if (!reset) npu_cnt = -1;
    else if (start_comp_npu) npu_cnt = npu_lat;
    else if (npu_cnt > 0) begin
      npu_cnt--;
      if (npu_cnt == 0) begin
        npu_done = 1'b1;
        npu_cnt = -1;
      end
    end
  end

  // Event logs of what the DUT actually did.
  int disp_q[$];
  int ret_q[$];
  int err_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (start_comp_npu) disp_q.push_back(int'(sel_task));
      if (retire_vld) ret_q.push_back(int'(retire_task_id));
      if (err_zero_layer) err_cnt++;
    end
  end

  // Timeline model: table of tasks plus the cycle numbers at which
  // the next pick, layer start and countdown are due.
  bit m_v[NS];
  int m_id[NS];
  int m_rem[NS];
  int cyc, pick_c, start_c, upd_c, run;
  bit waiting;
  bit e_busy, e_start, e_ret, e_err;
  int e_sel, e_rid;

  function automatic int m_count();
    int n = 0;
    foreach (m_v[i]) n += int'(m_v[i]);
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      foreach (m_v[i]) begin
        m_v[i] = 0; m_id[i] = 0; m_rem[i] = 0;
      end
      cyc = 0; pick_c = -1; start_c = -1; upd_c = -1;
      run = 0; waiting = 0;
      e_busy = 0; e_start = 0; e_ret = 0; e_err = 0;
      e_sel = 0; e_rid = 0;
    end else begin
      int free;
      int w;
      bit any_old;
      bit updated;
      free = -1;
      for (int i = NS - 1; i >= 0; i--) if (!m_v[i]) free = i;
      any_old = m_count() > 0;
      updated = 0;
      e_start = 0; e_ret = 0; e_err = 0;
      if (waiting && compute_done_npu) begin
        waiting = 0;
        upd_c = cyc + 1;
      end
      if (cyc == start_c) waiting = 1;
      if (cyc == pick_c) begin
        w = -1;
        for (int i = 0; i < NS; i++)
          if (m_v[i] && (w < 0 || m_rem[i] < m_rem[w])) w = i;
        run = w;
        e_sel = m_id[w];
        e_start = 1;
        start_c = cyc + 1;
      end
      if (cyc == upd_c) begin
        m_rem[run]--;
        if (m_rem[run] == 0) begin
          m_v[run] = 0;
          e_ret = 1;
          e_rid = m_id[run];
        end
        updated = 1;
      end
      if (req_vld && free >= 0) begin
        if (req_num_layers == 0) e_err = 1;
        else begin
          m_v[free] = 1;
          m_id[free] = int'(req_task_id);
          m_rem[free] = int'(req_num_layers);
        end
      end
      if (updated) begin
        if (m_count() > 0) pick_c = cyc + 1;
        else e_busy = 0;
      end else if (!e_busy && any_old) begin
        e_busy = 1;
        pick_c = cyc + 1;
      end
      cyc++;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en && reset) begin
      chk("start", start_comp_npu, e_start);
      chk("retire_vld", retire_vld, e_ret);
      if (e_ret) chk("retire_id", retire_task_id, e_rid);
      chk("err_zero", err_zero_layer, e_err);
      chk("busy", busy, e_busy);
      chk("sel_task", sel_task, e_sel);
      chk("req_rdy", req_rdy, m_count() < NS);
      chk("occupancy", occupancy, m_count());
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input int id, input int nl);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    req_vld = 1'b1;
    req_task_id = RD'(id);
    req_num_layers = LB'(nl);
    while (!req_rdy && n < 400) begin
      step(1);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL push_timeout: id %0d never accepted", id);
    end
    step(1);
    req_vld = 1'b0;
  endtask

  task automatic wait_start(input int lim);
    int n;
    n = 0;
    while (!start_comp_npu && n < lim) begin
      step(1);
      n++;
    end
    chk("wait_start_in_budget", n < lim, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((busy || occupancy != 0) && n < lim) begin
      step(1);
      n++;
    end
    chk("drain_in_budget", n < lim, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ex[$];
    int k;

    reset = 1'b0;
    step(3);
    chk("rst_sel", sel_task, 0);
    chk("rst_start", start_comp_npu, 0);
    chk("rst_retire", retire_vld, 0);
    chk("rst_retire_id", retire_task_id, 0);
    chk("rst_err", err_zero_layer, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", req_rdy, 1);
    reset = 1'b1;
    chk_en = 1;
    step(2);

    // single task, two layers
    disp_q.delete(); ret_q.delete();
    push(5, 2);
    k = 1;
    while (!start_comp_npu && k < 20) begin
      step(1);
      k++;
    end
    chk("s1_latency", k, 3);
    chk("s1_sel", sel_task, 5);
    wait_idle(200);
    ex = '{5, 5};
    chk_seq("s1_disp", disp_q, ex);
    ex = '{5};
    chk_seq("s1_ret", ret_q, ex);
    chk("s1_busy", busy, 0);

    // short task preempts at the layer boundary
    npu_lat = 10;
    step(2);
    disp_q.delete(); ret_q.delete();
    push(1, 4);
    wait_start(20);
    step(2);
    push(2, 1);
    wait_idle(500);
    ex = '{1, 2, 1, 1, 1};
    chk_seq("s2_disp", disp_q, ex);
    ex = '{2, 1};
    chk_seq("s2_ret", ret_q, ex);

    // equal remain: lower slot first
    npu_lat = 3;
    step(2);
    disp_q.delete(); ret_q.delete();
    push(7, 3);
    push(9, 3);
    wait_idle(500);
    ex = '{7, 7, 7, 9, 9, 9};
    chk_seq("s3_disp", disp_q, ex);
    ex = '{7, 9};
    chk_seq("s3_ret", ret_q, ex);

    // full table, back-pressure, refill on retire
    npu_lat = 40;
    step(2);
    disp_q.delete(); ret_q.delete();
    push(10, 1);
    for (int i = 1; i < NS; i++) push(10 + i, 5);
    chk("s4_full_occ", occupancy, 8);
    chk("s4_full_rdy", req_rdy, 0);
    @(negedge clk);
    #1;
    req_vld = 1'b1;
    req_task_id = RD'(20);
    req_num_layers = LB'(2);
    step(3);
    chk("s4_held_occ", occupancy, 8);
    chk("s4_held_rdy", req_rdy, 0);
    k = 0;
    while (!req_rdy && k < 200) begin
      step(1);
      k++;
    end
    chk("s4_rdy_in_budget", k < 200, 1);
    npu_lat = 2;
    step(1);
    req_vld = 1'b0;
    chk("s4_refill_occ", occupancy, 8);
    wait_idle(2000);
    ex = '{10, 11, 20, 20, 11, 11, 11, 11};
    for (int t = 12; t <= 17; t++) repeat (5) ex.push_back(t);
    chk_seq("s4_disp", disp_q, ex);
    ex = '{10, 20, 11, 12, 13, 14, 15, 16, 17};
    chk_seq("s4_ret", ret_q, ex);

    // zero-layer request and spurious done while idle
    step(2);
    disp_q.delete(); ret_q.delete();
    err_cnt = 0;
    push(30, 0);
    step(5);
    chk("s5_err_cnt", err_cnt, 1);
    chk("s5_occ", occupancy, 0);
    chk("s5_busy", busy, 0);
    chk("s5_no_start", disp_q.size(), 0);
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    step(3);
    chk("s5_spur_busy", busy, 0);
    chk("s5_spur_no_start", disp_q.size(), 0);

    // reset while a layer is in flight
    npu_lat = 30;
    disp_q.delete(); ret_q.delete();
    push(40, 3);
    push(41, 2);
    push(42, 4);
    step(3);
    chk("s6_pre_occ", occupancy, 3);
    chk("s6_pre_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("s6_sel", sel_task, 0);
    chk("s6_start", start_comp_npu, 0);
    chk("s6_retire", retire_vld, 0);
    chk("s6_occ", occupancy, 0);
    chk("s6_busy", busy, 0);
    chk("s6_rdy", req_rdy, 1);
    chk("s6_err", err_zero_layer, 0);
    step(2);
    reset = 1'b1;
    step(40);
    chk("s6_no_retire", ret_q.size(), 0);
    chk("s6_one_start", disp_q.size(), 1);
    chk("s6_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
